// File: rtl/sample_sequencer.sv
// Frame scheduler for the ADC -> processor -> DAC sample path: sampling tick,
// ADC start with timeout, processing delay, one DAC start pulse per frame.
module sample_sequencer #(
  parameter int DIV      = 5000,
  parameter int PROC_LAT = 4,
  parameter int TIMEOUT  = 2000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ch_mode,
  input  logic       ch_fixed,
  input  logic       clear,
  input  logic       data_valid,
  input  logic [9:0] data_in,
  output logic       adc_start,
  output logic       adc_channel,
  output logic [9:0] sample_out,
  output logic       sample_ch,
  output logic       dac_start,
  output logic       busy,
  output logic [7:0] overrun_cnt,
  output logic       timeout_err
);

  localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CMAX = (TIMEOUT > PROC_LAT) ? TIMEOUT : PROC_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PROCESS = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   tcnt_r;
  logic [CW-1:0]   cnt_r;
  logic            toggle_r;
  logic            tick_s;
  logic            timeout_hit_s;
  logic            overrun_s;

  assign tick_s        = enable && (tcnt_r == TW'(DIV - 1));
  // data_valid beats a timeout landing in the same cycle
  assign timeout_hit_s = (state_r == CONVERT) && !data_valid && (cnt_r == CW'(TIMEOUT));
  assign overrun_s     = tick_s && (state_r != IDLE);

  // Frame tick counter, held at zero while disabled
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= '0;
    end else if (!enable || tick_s) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_r + TW'(1);
    end
  end

  // Frame FSM with registered strobes, channel select and sample latch
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      toggle_r    <= 1'b0;
      adc_start   <= 1'b0;
      adc_channel <= 1'b0;
      sample_out  <= 10'h000;
      sample_ch   <= 1'b0;
      dac_start   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      dac_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r     <= CONVERT;
            busy        <= 1'b1;
            adc_start   <= 1'b1;
            adc_channel <= ch_mode ? toggle_r : ch_fixed;
            toggle_r    <= ~toggle_r;
            cnt_r       <= CW'(1);
          end
        end
        CONVERT: begin
          // cnt_r is the 1-based index of the current wait cycle
          if (data_valid) begin
            sample_out <= data_in;
            sample_ch  <= adc_channel;
            state_r    <= PROCESS;
            cnt_r      <= CW'(1);
          end else if (timeout_hit_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        PROCESS: begin
          if (cnt_r == CW'(PROC_LAT)) begin
            state_r   <= OUTPUT;
            dac_start <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        OUTPUT: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Debug status: saturating overrun count and sticky timeout flag
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= 8'h00;
      timeout_err <= 1'b0;
    end else if (clear) begin
      overrun_cnt <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      if (overrun_s && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'h01;
      end
      if (timeout_hit_s) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
